axis_pkt_gen: RTL and testbench

Parametrised AXI-Stream packet generator driving the block-design stream slave (S_AXIS) in the clk_200 domain. Successor to the fixed 16-bit stream source: width, packet length and inter-packet gap are configurable, with counter or PRBS payload and a packet counter for software and bench checking. Sits in the top level between the control registers and the design_1 stream input.

---
 rtl/axis_pkt_gen.sv | 190 +++++++++++++++++++
 tb/tb_axis_pkt_gen.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_gen.sv
// axis_pkt_gen: AXI-Stream packet generator with configurable length, gap and counter payload.
// Define AXIS_PKT_GEN_PRBS_EN to add the PRBS-15 payload selected by the mode input.
module axis_pkt_gen #(
  parameter int DATA_W = 16,
  parameter int LEN_W  = 16,
  parameter int GAP_W  = 8
) (
  input  logic              clk_200,
  input  logic              sys_arstn,
  input  logic              enable,
  input  logic              mode,
  input  logic [LEN_W-1:0]  pkt_len,
  input  logic [GAP_W-1:0]  gap_len,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  output logic              m_axis_tlast,
  input  logic              m_axis_tready,
  output logic [31:0]       pkt_cnt,
  output logic              busy,
  output logic [1:0]        state_dbg
);
  // Handshake: a beat transfers on a clock edge where tvalid && tready; once tvalid rises,
  // tvalid, tdata and tlast hold until that transfer, and tvalid never waits on tready.
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  beat_q, beat_d, len_q, len_d;
  logic [LEN_W-1:0]  eff_len, beat_inc, data_idx;
  logic [GAP_W-1:0]  gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [31:0]       pkt_cnt_q, pkt_cnt_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d, tlast_q, tlast_d, busy_q, busy_d;
  logic              hs, start, load;

  function automatic logic [DATA_W-1:0] cnt_word(input logic [LEN_W-1:0] idx);
    logic [LEN_W+DATA_W-1:0] w;
    w = {{DATA_W{1'b0}}, idx};
    return w[DATA_W-1:0];
  endfunction

`ifdef AXIS_PKT_GEN_PRBS_EN
  logic [14:0] lfsr_q, lfsr_d, lfsr_next;
  logic        mode_q, mode_d, data_md;

  function automatic logic [DATA_W-1:0] prbs_word(input logic [14:0] s);
    logic [15+DATA_W-1:0] w;
    w = {{DATA_W{1'b0}}, s};
    return w[DATA_W-1:0];
  endfunction

  // x^15 + x^14 + 1, shifting toward the MSB
  assign lfsr_next = {lfsr_q[13:0], lfsr_q[14] ^ lfsr_q[13]};
`else
  logic unused_mode;
  assign unused_mode = mode;
`endif

  assign hs       = tvalid_q && m_axis_tready;
  assign eff_len  = (pkt_len == '0) ? LEN_W'(1) : pkt_len;
  assign beat_inc = beat_q + LEN_W'(1);

  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    len_d     = len_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tdata_d   = tdata_q;
    start     = 1'b0;
    load      = 1'b0;
    data_idx  = '0;
`ifdef AXIS_PKT_GEN_PRBS_EN
    lfsr_d    = hs ? lfsr_next : lfsr_q;
    mode_d    = mode_q;
    data_md   = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (enable) start = 1'b1;
      end
      SEND: begin
        if (hs) begin
          if (!tlast_q) begin
            beat_d   = beat_inc;
            tlast_d  = (beat_inc == len_q - LEN_W'(1));
            load     = 1'b1;
            data_idx = beat_inc;
          end else begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
            if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
              tvalid_d  = 1'b0;
              tlast_d   = 1'b0;
            end else if (enable) begin
              start = 1'b1;
            end else begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
            end
          end
        end
      end
      GAP: begin
        gap_cnt_d = gap_cnt_q - GAP_W'(1);
        if (gap_cnt_q == GAP_W'(1)) begin
          if (enable) start = 1'b1;
          else state_d = IDLE;
        end
      end
      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
      end
    endcase
    // Every packet start (from IDLE, back-to-back or after a gap) relatches the config.
    if (start) begin
      state_d  = SEND;
      len_d    = eff_len;
      gap_d    = gap_len;
      beat_d   = '0;
      tvalid_d = 1'b1;
      tlast_d  = (eff_len == LEN_W'(1));
      load     = 1'b1;
      data_idx = '0;
`ifdef AXIS_PKT_GEN_PRBS_EN
      mode_d   = mode;
      data_md  = mode;
`endif
    end
    if (load) begin
`ifdef AXIS_PKT_GEN_PRBS_EN
      tdata_d = data_md ? prbs_word(lfsr_d) : cnt_word(data_idx);
`else
      tdata_d = cnt_word(data_idx);
`endif
    end
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_200 or negedge sys_arstn) begin
    if (!sys_arstn) begin
      state_q   <= IDLE;
      beat_q    <= '0;
      len_q     <= LEN_W'(1);
      gap_q     <= '0;
      gap_cnt_q <= '0;
      pkt_cnt_q <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tdata_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tdata_q   <= tdata_d;
      busy_q    <= busy_d;
    end
  end

`ifdef AXIS_PKT_GEN_PRBS_EN
  always_ff @(posedge clk_200 or negedge sys_arstn) begin
    if (!sys_arstn) begin
      lfsr_q <= 15'h7FFF;
      mode_q <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      mode_q <= mode_d;
    end
  end
`endif

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign pkt_cnt       = pkt_cnt_q;
  assign busy          = busy_q;
  assign state_dbg     = state_q;
endmodule

// File: tb/tb_axis_pkt_gen.sv
// Bench for axis_pkt_gen: scenario tasks driving randomized stimulus, checked against a
// beat-level reference model (expected queue of payload/tlast, packet and LFSR counters).
module tb_axis_pkt_gen;
  localparam int DATA_W = 16;
  localparam int LEN_W  = 16;
  localparam int GAP_W  = 8;
`ifdef AXIS_PKT_GEN_PRBS_EN
  localparam bit PRBS_EN = 1'b1;
`else
  localparam bit PRBS_EN = 1'b0;
`endif

  logic              clk_200 = 1'b0;
  logic              sys_arstn = 1'b0;
  logic              enable = 1'b0;
  logic              mode = 1'b0;
  logic [LEN_W-1:0]  pkt_len = '0;
  logic [GAP_W-1:0]  gap_len = '0;
  logic              m_axis_tready = 1'b0;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic [31:0]       pkt_cnt;
  logic              busy;
  logic [1:0]        state_dbg;

  int checks = 0;
  int failures = 0;
  int m_lfsr = 32'h7FFF;
  logic [31:0] m_pkt_cnt = '0;
  logic [DATA_W-1:0] exp_q[$];
  bit exp_last_q[$];

  axis_pkt_gen dut (
    .clk_200(clk_200), .sys_arstn(sys_arstn), .enable(enable), .mode(mode),
    .pkt_len(pkt_len), .gap_len(gap_len), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .pkt_cnt(pkt_cnt), .busy(busy), .state_dbg(state_dbg)
  );

  always #5 clk_200 = ~clk_200;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic int prbs_step(input int s);
    return ((s << 1) | (((s >> 14) ^ (s >> 13)) & 1)) & 32'h7FFF;
  endfunction

  function automatic logic [DATA_W-1:0] model_beat(input int idx, input bit md, input int lfsr);
    if (md && PRBS_EN) return DATA_W'(lfsr);
    return DATA_W'(idx);
  endfunction

  task automatic plan_packet(input int len, input bit md);
    int n;
    n = (len == 0) ? 1 : len;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(model_beat(i, md, m_lfsr));
      exp_last_q.push_back(i == n - 1);
      m_lfsr = prbs_step(m_lfsr);
    end
  endtask

  task automatic tick();
    @(posedge clk_200);
    #1;
  endtask

  task automatic do_reset();
    sys_arstn = 1'b0;
    enable = 1'b0;
    repeat (2) @(posedge clk_200);
    #3;
    sys_arstn = 1'b1;
    tick();
    m_lfsr = 32'h7FFF;
    m_pkt_cnt = '0;
    exp_q.delete();
    exp_last_q.delete();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    sys_arstn = 1'b0;
    enable = 1'b0;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk_200);
    #1;
    checks++; if (m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); end
    checks++; if (m_axis_tlast !== 1'b0) begin failures++; $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); end
    checks++; if (m_axis_tdata !== '0) begin failures++; $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); end
    checks++; if (pkt_cnt !== 32'd0) begin failures++; $display("FAIL reset_pkt_cnt: got %0d want 0", pkt_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
    #3;
    sys_arstn = 1'b1;
    repeat (2) tick();
    checks++; if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL idle_no_enable: tvalid=%b busy=%b want 0/0", m_axis_tvalid, busy); end
    m_lfsr = 32'h7FFF;
    m_pkt_cnt = '0;
  endtask

  task automatic test_basic();
    logic [31:0] base;
    logic [DATA_W-1:0] exp_d;
    bit exp_l;
    base = m_pkt_cnt;
    pkt_len = LEN_W'(4); gap_len = '0; mode = 1'b0; m_axis_tready = 1'b1;
    plan_packet(4, 1'b0);
    plan_packet(4, 1'b0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 4) enable = 1'b0;
      exp_d = exp_q.pop_front();
      exp_l = exp_last_q.pop_front();
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d || m_axis_tlast !== exp_l || busy !== 1'b1) begin
        failures++;
        $display("FAIL basic_beat%0d: tvalid=%b tdata=%h tlast=%b busy=%b want 1/%h/%b/1", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, busy, exp_d, exp_l);
      end
      checks++;
      if (pkt_cnt !== base + 32'(i / 4)) begin failures++; $display("FAIL basic_pkt_cnt%0d: got %0d want %0d", i, pkt_cnt, base + 32'(i / 4)); end
      tick();
    end
    m_pkt_cnt = m_pkt_cnt + 32'd2;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== m_pkt_cnt) begin
      failures++;
      $display("FAIL basic_end: tvalid=%b busy=%b pkt_cnt=%0d want 0/0/%0d", m_axis_tvalid, busy, pkt_cnt, m_pkt_cnt);
    end
  endtask

  task automatic test_gap();
    int accepted, low, cyc;
    logic [DATA_W-1:0] exp_d;
    bit exp_l;
    pkt_len = LEN_W'(3); gap_len = GAP_W'(5); mode = 1'b0; m_axis_tready = 1'b1;
    for (int p = 0; p < 3; p++) plan_packet(3, 1'b0);
    enable = 1'b1;
    tick();
    accepted = 0; low = 0; cyc = 0;
    while (accepted < 9 && cyc < 200) begin
      if (m_axis_tvalid && accepted >= 6) enable = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL gap_busy cyc%0d: got %b want 1", cyc, busy); end
      if (m_axis_tvalid) begin
        if (accepted > 0 && accepted % 3 == 0) begin
          checks++; if (low != 5) begin failures++; $display("FAIL gap_len pkt%0d: got %0d idle cycles want 5", accepted / 3, low); end
        end
        low = 0;
        exp_d = exp_q.pop_front();
        exp_l = exp_last_q.pop_front();
        checks++;
        if (m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
          failures++;
          $display("FAIL gap_beat%0d: tdata=%h tlast=%b want %h/%b", accepted, m_axis_tdata, m_axis_tlast, exp_d, exp_l);
        end
        accepted++;
      end else begin
        low++;
      end
      tick();
      cyc++;
    end
    checks++; if (accepted != 9) begin failures++; $display("FAIL gap_timeout: got %0d beats want 9", accepted); end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (busy !== 1'b1 || m_axis_tvalid !== 1'b0) begin failures++; $display("FAIL gap_tail%0d: busy=%b tvalid=%b want 1/0", k, busy, m_axis_tvalid); end
      tick();
    end
    m_pkt_cnt = m_pkt_cnt + 32'd3;
    checks++;
    if (busy !== 1'b0 || pkt_cnt !== m_pkt_cnt) begin failures++; $display("FAIL gap_end: busy=%b pkt_cnt=%0d want 0/%0d", busy, pkt_cnt, m_pkt_cnt); end
    exp_q.delete();
    exp_last_q.delete();
  endtask

  task automatic test_stall();
    int accepted, cyc;
    bit have_prev, md, prev_last;
    logic [DATA_W-1:0] prev_data, exp_d;
    bit exp_l;
    md = 1'($urandom_range(0, 1));
    pkt_len = LEN_W'(8); gap_len = '0; mode = md;
    plan_packet(8, md);
    enable = 1'b1;
    tick();
    accepted = 0; cyc = 0; have_prev = 1'b0; prev_data = '0; prev_last = 1'b0;
    while (accepted < 8 && cyc < 400) begin
      m_axis_tready = ($urandom_range(0, 99) < 40);
      if (m_axis_tvalid) enable = 1'b0;
      if (have_prev) begin
        checks++;
        if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last) begin
          failures++;
          $display("FAIL stall_hold cyc%0d: tvalid=%b tdata=%h tlast=%b want 1/%h/%b", cyc, m_axis_tvalid, m_axis_tdata, m_axis_tlast, prev_data, prev_last);
        end
      end
      if (m_axis_tvalid && m_axis_tready) begin
        exp_d = exp_q.pop_front();
        exp_l = exp_last_q.pop_front();
        checks++;
        if (m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
          failures++;
          $display("FAIL stall_beat%0d: tdata=%h tlast=%b want %h/%b", accepted, m_axis_tdata, m_axis_tlast, exp_d, exp_l);
        end
        accepted++;
        have_prev = 1'b0;
      end else if (m_axis_tvalid) begin
        have_prev = 1'b1;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
      end
      tick();
      cyc++;
    end
    checks++; if (accepted != 8) begin failures++; $display("FAIL stall_timeout: got %0d beats want 8", accepted); end
    m_pkt_cnt = m_pkt_cnt + 32'd1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== m_pkt_cnt) begin
      failures++;
      $display("FAIL stall_end: tvalid=%b busy=%b pkt_cnt=%0d want 0/0/%0d", m_axis_tvalid, busy, pkt_cnt, m_pkt_cnt);
    end
    exp_q.delete();
    exp_last_q.delete();
  endtask

  task automatic test_random();
    int len, gap, n, accepted, cyc;
    bit md, exp_l;
    logic [DATA_W-1:0] exp_d;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(0, 5);
      gap = $urandom_range(0, 3);
      md = 1'($urandom_range(0, 1));
      n = (len == 0) ? 1 : len;
      pkt_len = LEN_W'(len); gap_len = GAP_W'(gap); mode = md;
      plan_packet(len, md);
      plan_packet(len, md);
      enable = 1'b1;
      tick();
      accepted = 0; cyc = 0;
      while (accepted < 2 * n && cyc < 300) begin
        m_axis_tready = ($urandom_range(0, 99) < 70);
        if (m_axis_tvalid && accepted >= n) enable = 1'b0;
        if (m_axis_tvalid && m_axis_tready) begin
          exp_d = exp_q.pop_front();
          exp_l = exp_last_q.pop_front();
          checks++;
          if (m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
            failures++;
            $display("FAIL rand%0d_beat%0d: tdata=%h tlast=%b want %h/%b (len=%0d mode=%0d)", r, accepted, m_axis_tdata, m_axis_tlast, exp_d, exp_l, len, md);
          end
          accepted++;
        end
        tick();
        cyc++;
      end
      checks++; if (accepted != 2 * n) begin failures++; $display("FAIL rand%0d_timeout: got %0d beats want %0d", r, accepted, 2 * n); end
      cyc = 0;
      while (busy === 1'b1 && cyc < 20) begin tick(); cyc++; end
      m_pkt_cnt = m_pkt_cnt + 32'd2;
      checks++;
      if (busy !== 1'b0 || m_axis_tvalid !== 1'b0 || pkt_cnt !== m_pkt_cnt) begin
        failures++;
        $display("FAIL rand%0d_end: busy=%b tvalid=%b pkt_cnt=%0d want 0/0/%0d", r, busy, m_axis_tvalid, pkt_cnt, m_pkt_cnt);
      end
      exp_q.delete();
      exp_last_q.delete();
    end
  endtask

  task automatic test_enable_drop();
    logic [31:0] base;
    logic [DATA_W-1:0] exp_d;
    bit exp_l;
    base = m_pkt_cnt;
    pkt_len = LEN_W'(6); gap_len = '0; mode = 1'b0; m_axis_tready = 1'b1;
    plan_packet(6, 1'b0);
    enable = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        enable = 1'b0;
        pkt_len = LEN_W'(2);
      end
      exp_d = exp_q.pop_front();
      exp_l = exp_last_q.pop_front();
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
        failures++;
        $display("FAIL drop_beat%0d: tvalid=%b tdata=%h tlast=%b want 1/%h/%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_d, exp_l);
      end
      tick();
    end
    m_pkt_cnt = m_pkt_cnt + 32'd1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== base + 32'd1) begin
      failures++;
      $display("FAIL drop_end: tvalid=%b busy=%b pkt_cnt=%0d want 0/0/%0d", m_axis_tvalid, busy, pkt_cnt, base + 32'd1);
    end
  endtask

  task automatic test_prbs();
    logic [DATA_W-1:0] want0, want1;
    want0 = PRBS_EN ? DATA_W'(16'h7FFF) : DATA_W'(0);
    want1 = PRBS_EN ? DATA_W'(16'h7FFE) : DATA_W'(1);
    do_reset();
    pkt_len = LEN_W'(2); gap_len = '0; mode = 1'b1; m_axis_tready = 1'b1;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== want0 || m_axis_tlast !== 1'b0) begin
      failures++; $display("FAIL prbs_beat0: tvalid=%b tdata=%h tlast=%b want 1/%h/0", m_axis_tvalid, m_axis_tdata, m_axis_tlast, want0);
    end
    tick();
    checks++;
    if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== want1 || m_axis_tlast !== 1'b1) begin
      failures++; $display("FAIL prbs_beat1: tvalid=%b tdata=%h tlast=%b want 1/%h/1", m_axis_tvalid, m_axis_tdata, m_axis_tlast, want1);
    end
    tick();
    m_lfsr = prbs_step(prbs_step(m_lfsr));
    m_pkt_cnt = 32'd1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || pkt_cnt !== m_pkt_cnt) begin
      failures++; $display("FAIL prbs_end: tvalid=%b pkt_cnt=%0d want 0/%0d", m_axis_tvalid, pkt_cnt, m_pkt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    logic [DATA_W-1:0] exp_d;
    bit exp_l;
    pkt_len = LEN_W'(8); gap_len = '0; mode = 1'b1; m_axis_tready = 1'b1;
    enable = 1'b1;
    repeat (4) tick();
    #2;
    sys_arstn = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== '0 || pkt_cnt !== 32'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs: tvalid=%b tlast=%b tdata=%h pkt_cnt=%0d busy=%b want all 0", m_axis_tvalid, m_axis_tlast, m_axis_tdata, pkt_cnt, busy);
    end
    m_lfsr = 32'h7FFF;
    m_pkt_cnt = '0;
    exp_q.delete();
    exp_last_q.delete();
    plan_packet(8, 1'b1);
    sys_arstn = 1'b1;
    tick();
    enable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_d = exp_q.pop_front();
      exp_l = exp_last_q.pop_front();
      checks++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== exp_d || m_axis_tlast !== exp_l) begin
        failures++;
        $display("FAIL midreset_beat%0d: tvalid=%b tdata=%h tlast=%b want 1/%h/%b", i, m_axis_tvalid, m_axis_tdata, m_axis_tlast, exp_d, exp_l);
      end
      tick();
    end
    m_pkt_cnt = 32'd1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || busy !== 1'b0 || pkt_cnt !== m_pkt_cnt) begin
      failures++;
      $display("FAIL midreset_end: tvalid=%b busy=%b pkt_cnt=%0d want 0/0/%0d", m_axis_tvalid, busy, pkt_cnt, m_pkt_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_stall();
    test_enable_drop();
    test_random();
    test_prbs();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
